alu_exec_ctrl: RTL

- Sequences one ALU8 operation per accepted instruction for the Mini-CPU byte-oriented datapath.
- Reads the file-register operand, drives all ALU8 control and operand lines, captures result and flags, then writes back to W or the file register.
- Owns the W register and the STATUS C/DC/Z bits.
- Sits between the instruction decoder (valid/ready handshake) and the ALU8 plus file register array.

---
 rtl/alu_exec_ctrl_if.sv | 18 +
 rtl/alu_exec_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake between the decoder (master) and alu_exec_ctrl (slave).
// The decoder holds the fields stable while instr_valid is high.
interface alu_exec_ctrl_if #(
  parameter int FADDR_W = 7,
  parameter int DATA_W  = 8
);
  logic               instr_valid;
  logic               instr_ready;
  logic [3:0]         instr_op;
  logic               instr_d;
  logic [FADDR_W-1:0] instr_f;
  logic [DATA_W-1:0]  instr_k;

  modport master (output instr_valid, instr_op, instr_d, instr_f, instr_k,
                  input  instr_ready);
  modport slave  (input  instr_valid, instr_op, instr_d, instr_f, instr_k,
                  output instr_ready);
endinterface

// File: rtl/alu_exec_ctrl.sv
// ALU8 execution sequencer: one operation per accepted instruction, owns W and STATUS C/DC/Z.
// Define ALU_CTRL_LITERAL_EN to enable MOVLW (14) / ADDLW (15); otherwise they report illegal.
//
// state  | meaning
// S_IDLE | ready for an instruction, latch fields on instr_valid
// S_READ | file read strobe out, data returns next cycle
// S_EXEC | ALU driven from file data (or literal) and W, result/flags captured
// S_WB   | file write strobe, done/illegal pulse, W and STATUS commit at exit
module alu_exec_ctrl #(
  parameter int FADDR_W = 7,
  parameter int DATA_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  alu_exec_ctrl_if.slave     instr,
  output logic               f_rd_en,
  output logic [FADDR_W-1:0] f_rd_addr,
  input  logic [DATA_W-1:0]  f_rd_data,
  output logic               f_wr_en,
  output logic [FADDR_W-1:0] f_wr_addr,
  output logic [DATA_W-1:0]  f_wr_data,
  output logic               alu_clr,
  output logic               alu_swap_n_mov,
  output logic               alu_rlf_n_rrf,
  output logic               alu_sub,
  output logic               alu_c_in,
  output logic [1:0]         alu_op_mux_l,
  output logic [1:0]         alu_op_mux_a,
  output logic [1:0]         alu_out_mux,
  output logic [DATA_W-1:0]  alu_op_a,
  output logic [DATA_W-1:0]  alu_op_b,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_c,
  input  logic               alu_dc,
  input  logic               alu_z,
  output logic [DATA_W-1:0]  w_reg,
  output logic               status_c,
  output logic               status_dc,
  output logic               status_z,
  output logic               done,
  output logic               illegal
);

  localparam logic [3:0] OP_ADDWF = 4'd0;
  localparam logic [3:0] OP_SUBWF = 4'd1;
  localparam logic [3:0] OP_INCF  = 4'd2;
  localparam logic [3:0] OP_DECF  = 4'd3;
  localparam logic [3:0] OP_IORWF = 4'd4;
  localparam logic [3:0] OP_ANDWF = 4'd5;
  localparam logic [3:0] OP_XORWF = 4'd6;
  localparam logic [3:0] OP_COMF  = 4'd7;
  localparam logic [3:0] OP_MOVF  = 4'd8;
  localparam logic [3:0] OP_SWAPF = 4'd9;
  localparam logic [3:0] OP_RLF   = 4'd10;
  localparam logic [3:0] OP_RRF   = 4'd11;
  localparam logic [3:0] OP_CLRF  = 4'd12;
  localparam logic [3:0] OP_MOVWF = 4'd13;
`ifdef ALU_CTRL_LITERAL_EN
  localparam logic [3:0] OP_MOVLW = 4'd14;
`endif

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  state_t              state;
  logic [3:0]          op_q;
  logic                d_q;
  logic [FADDR_W-1:0]  f_q;
  logic [DATA_W-1:0]   k_q;
  logic [DATA_W-1:0]  res_q;
  logic                c_q, dc_q, z_q;

  logic                n_clr, n_swap, n_rlf, n_sub, n_cin;
  logic [1:0]          n_mux_l, n_mux_a, n_out_mux;
  logic                upd_c, upd_dc, upd_z;
  logic                to_file, to_w, lit_op, bad_op;

  always_comb begin
    n_clr     = 1'b0;
    n_swap    = 1'b0;
    n_rlf     = 1'b0;
    n_sub     = 1'b0;
    n_cin     = 1'b0;
    n_mux_l   = 2'd0;
    n_mux_a   = 2'd0;
    n_out_mux = 2'd0;
    upd_c     = 1'b0;
    upd_dc    = 1'b0;
    upd_z     = 1'b0;
    to_file   = d_q;
    to_w      = ~d_q;
    lit_op    = 1'b0;
    bad_op    = 1'b0;
    case (op_q)
      OP_ADDWF: begin upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1; end
      OP_SUBWF: begin
        n_mux_a = 2'd1; n_sub = 1'b1;
        upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1;
      end
      OP_INCF:  begin n_mux_a = 2'd2; upd_z = 1'b1; end
      OP_DECF:  begin n_mux_a = 2'd3; n_sub = 1'b1; upd_z = 1'b1; end
      OP_IORWF: begin n_out_mux = 2'd1; n_mux_l = 2'd0; upd_z = 1'b1; end
      OP_ANDWF: begin n_out_mux = 2'd1; n_mux_l = 2'd1; upd_z = 1'b1; end
      OP_XORWF: begin n_out_mux = 2'd1; n_mux_l = 2'd2; upd_z = 1'b1; end
      OP_COMF:  begin n_out_mux = 2'd1; n_mux_l = 2'd3; upd_z = 1'b1; end
      OP_MOVF:  begin n_out_mux = 2'd3; upd_z = 1'b1; end
      OP_SWAPF: begin n_out_mux = 2'd3; n_swap = 1'b1; end
      OP_RLF:   begin n_out_mux = 2'd2; n_rlf = 1'b1; n_cin = status_c; upd_c = 1'b1; end
      OP_RRF:   begin n_out_mux = 2'd2; n_cin = status_c; upd_c = 1'b1; end
      OP_CLRF:  begin n_clr = 1'b1; upd_z = 1'b1; to_file = 1'b1; to_w = 1'b0; end
      OP_MOVWF: begin to_file = 1'b1; to_w = 1'b0; end
      default: begin
`ifdef ALU_CTRL_LITERAL_EN
        lit_op  = 1'b1;
        to_file = 1'b0;
        to_w    = 1'b1;
        if (op_q == OP_MOVLW) n_out_mux = 2'd3;
        else begin upd_c = 1'b1; upd_dc = 1'b1; upd_z = 1'b1; end
`else
        bad_op  = 1'b1;
        to_file = 1'b0;
        to_w    = 1'b0;
`endif
      end
    endcase
  end

  // File data only exists during EXEC, so operands are steered combinationally.
  assign alu_op_a          = (state == S_EXEC) ? (lit_op ? k_q : f_rd_data) : '0;
  assign alu_op_b          = (state == S_EXEC) ? w_reg : '0;
  assign instr.instr_ready = (state == S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= '0;
      d_q            <= 1'b0;
      f_q            <= '0;
      k_q            <= '0;
      res_q          <= '0;
      c_q            <= 1'b0;
      dc_q           <= 1'b0;
      z_q            <= 1'b0;
      w_reg          <= '0;
      status_c       <= 1'b0;
      status_dc      <= 1'b0;
      status_z       <= 1'b0;
      f_rd_en        <= 1'b0;
      f_rd_addr      <= '0;
      f_wr_en        <= 1'b0;
      f_wr_addr      <= '0;
      f_wr_data      <= '0;
      done           <= 1'b0;
      illegal        <= 1'b0;
      alu_clr        <= 1'b0;
      alu_swap_n_mov <= 1'b0;
      alu_rlf_n_rrf  <= 1'b0;
      alu_sub        <= 1'b0;
      alu_c_in       <= 1'b0;
      alu_op_mux_l   <= 2'd0;
      alu_op_mux_a   <= 2'd0;
      alu_out_mux    <= 2'd0;
    end else begin
      f_rd_en <= 1'b0;
      f_wr_en <= 1'b0;
      done    <= 1'b0;
      illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr.instr_valid) begin
            op_q      <= instr.instr_op;
            d_q       <= instr.instr_d;
            f_q       <= instr.instr_f;
            k_q       <= instr.instr_k;
            f_rd_en   <= 1'b1;
            f_rd_addr <= instr.instr_f;
            state     <= S_READ;
          end
        end
        S_READ: begin
          alu_clr        <= n_clr;
          alu_swap_n_mov <= n_swap;
          alu_rlf_n_rrf  <= n_rlf;
          alu_sub        <= n_sub;
          alu_c_in       <= n_cin;
          alu_op_mux_l   <= n_mux_l;
          alu_op_mux_a   <= n_mux_a;
          alu_out_mux    <= n_out_mux;
          state          <= S_EXEC;
        end
        S_EXEC: begin
          res_q          <= alu_result;
          c_q            <= alu_c;
          dc_q           <= alu_dc;
          z_q            <= (op_q == OP_CLRF) ? 1'b1 : alu_z;
          f_wr_en        <= to_file;
          f_wr_addr      <= f_q;
          f_wr_data      <= (op_q == OP_MOVWF) ? w_reg : alu_result;
          done           <= 1'b1;
          illegal        <= bad_op;
          alu_clr        <= 1'b0;
          alu_swap_n_mov <= 1'b0;
          alu_rlf_n_rrf  <= 1'b0;
          alu_sub        <= 1'b0;
          alu_c_in       <= 1'b0;
          alu_op_mux_l   <= 2'd0;
          alu_op_mux_a   <= 2'd0;
          alu_out_mux    <= 2'd0;
          state          <= S_WB;
        end
        S_WB: begin
          if (to_w)   w_reg     <= res_q;
          if (upd_c)  status_c  <= c_q;
          if (upd_dc) status_dc <= dc_q;
          if (upd_z)  status_z  <= z_q;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
